// File: rtl/ibex_instr_bus_arbiter.sv
// Round-robin arbiter sharing the core instruction-memory port between two fetch
// requesters, with an in-order owner FIFO that routes each response to its owner.
module ibex_instr_bus_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic [31:0] addr0_i,
  output logic        gnt0_o,
  output logic        rvalid0_o,
  input  logic        req1_i,
  input  logic [31:0] addr1_i,
  output logic        gnt1_o,
  output logic        rvalid1_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic                      lock_q;
  logic                      sel_q;
  logic                      last_q;
  logic [MaxOutstanding-1:0] owner_q;
  logic [PtrW-1:0]           wr_ptr_q;
  logic [PtrW-1:0]           rd_ptr_q;
  logic [CntW-1:0]           count_q;

  logic sel;
  logic req_sel;
  logic grant;
  logic pop;
  logic head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  // A locked selection holds the memory-side address steady across wait states.
  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = sel_q;
    end else if (req0_i ^ req1_i) begin
      sel = req1_i;
    end else if (req0_i && req1_i) begin
      sel = ~last_q;
    end
  end

  assign req_sel      = sel ? req1_i : req0_i;
  assign instr_req_o  = ~rst_i & req_sel & (count_q < CntW'(MaxOutstanding));
  assign instr_addr_o = (sel && !rst_i) ? addr1_i : addr0_i;
  assign grant        = instr_req_o & instr_gnt_i;
  assign gnt0_o       = grant & ~sel;
  assign gnt1_o       = grant & sel;

  assign pop       = ~rst_i & instr_rvalid_i & (count_q != '0);
  assign head      = owner_q[rd_ptr_q];
  assign rvalid0_o = pop & ~head;
  assign rvalid1_o = pop & head;
  assign rdata_o   = instr_rdata_i;
  assign err_o     = instr_err_i;
  assign busy_o    = ~rst_i & (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q   <= 1'b0;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (grant) begin
        lock_q            <= 1'b0;
        last_q            <= sel;
        owner_q[wr_ptr_q] <= sel;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end else if (instr_req_o) begin
        lock_q <= 1'b1;
        sel_q  <= sel;
      end else begin
        lock_q <= 1'b0;
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      // Simultaneous grant and pop leave the occupancy unchanged.
      if (grant && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !grant) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Responses still in flight when reset hit may trickle in until the next grant.
  logic stale_ok_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stale_ok_q <= 1'b1;
    end else if (grant) begin
      stale_ok_q <= 1'b0;
    end
  end

  a_one_grant: assert property (@(posedge clk_i) disable iff (rst_i) !(gnt0_o && gnt1_o));
  a_count_max: assert property (@(posedge clk_i) disable iff (rst_i)
                                count_q <= CntW'(MaxOutstanding));
  a_no_orphan: assert property (@(posedge clk_i) disable iff (rst_i)
                                !(instr_rvalid_i && count_q == '0 && !stale_ok_q));
  a_addr_hold: assert property (@(posedge clk_i) disable iff (rst_i)
                                instr_req_o && !instr_gnt_i |=> $stable(instr_addr_o));

endmodule

// File: tb/tb_ibex_instr_bus_arbiter.sv
// Self-checking bench for ibex_instr_bus_arbiter: directed scenarios plus a
// randomized run checked against a queue-based model of the arbitration rules.
module tb_ibex_instr_bus_arbiter;
  localparam int MaxOut = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req0_i = 1'b0, req1_i = 1'b0;
  logic [31:0] addr0_i = '0, addr1_i = '0;
  logic        gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, err_o, busy_o;
  logic [31:0] rdata_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0, instr_err_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  ibex_instr_bus_arbiter #(.MaxOutstanding(MaxOut)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_i(req0_i), .addr0_i(addr0_i), .gnt0_o(gnt0_o), .rvalid0_o(rvalid0_o),
    .req1_i(req1_i), .addr1_i(addr1_i), .gnt1_o(gnt1_o), .rvalid1_o(rvalid1_o),
    .rdata_o(rdata_o), .err_o(err_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
    .busy_o(busy_o)
  );

  // Status bits: {gnt0, gnt1, instr_req, rvalid0, rvalid1, busy}
  function automatic logic [5:0] status();
    return {gnt0_o, gnt1_o, instr_req_o, rvalid0_o, rvalid1_o, busy_o};
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    req0_i = 0; req1_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0; instr_err_i = 0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_i = 1;
    next_cycle();
    rst_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1; req0_i = 1; req1_i = 1; addr0_i = 32'hAAAA_0000; addr1_i = 32'h5555_0000;
    instr_gnt_i = 1; instr_rvalid_i = 1;
    next_cycle();
    @(negedge clk_i);
    n_checks++;
    if (status() !== 6'b000000) begin
      n_fail++; $display("[TB] FAIL reset_status: got %b want %b", status(), 6'b000000);
    end
    n_checks++;
    if (instr_addr_o !== 32'hAAAA_0000) begin
      n_fail++; $display("[TB] FAIL reset_addr: got %h want %h", instr_addr_o, 32'hAAAA_0000);
    end
    idle_inputs(); rst_i = 0; addr0_i = 32'h1234_5678;
    next_cycle();
    @(negedge clk_i);
    n_checks++;
    if (status() !== 6'b000000) begin
      n_fail++; $display("[TB] FAIL idle_status: got %b want %b", status(), 6'b000000);
    end
    n_checks++;
    if (instr_addr_o !== 32'h1234_5678) begin
      n_fail++; $display("[TB] FAIL idle_addr: got %h want %h", instr_addr_o, 32'h1234_5678);
    end
  endtask

  task automatic test_single();
    logic [5:0] want [4] = '{6'b101000, 6'b000001, 6'b000101, 6'b000000};
    reset_dut();
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      if (c == 0) begin req0_i = 1; addr0_i = 32'h0000_0080; instr_gnt_i = 1; end
      if (c == 2) begin instr_rvalid_i = 1; instr_rdata_i = 32'h0000_0013; end
      @(negedge clk_i);
      n_checks++;
      if (status() !== want[c]) begin
        n_fail++; $display("[TB] FAIL single_status c%0d: got %b want %b", c, status(), want[c]);
      end
      if (c == 0) begin
        n_checks++;
        if (instr_addr_o !== 32'h0000_0080) begin
          n_fail++; $display("[TB] FAIL single_addr: got %h want %h", instr_addr_o, 32'h80);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (rdata_o !== 32'h0000_0013) begin
          n_fail++; $display("[TB] FAIL single_rdata: got %h want %h", rdata_o, 32'h13);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    logic [5:0]  want;
    logic [31:0] want_addr;
    reset_dut();
    req0_i = 1; req1_i = 1; addr0_i = 32'h0000_0100; addr1_i = 32'h0000_0200; instr_gnt_i = 1;
    for (int i = 0; i < 6; i++) begin
      instr_rvalid_i = (i > 0);
      want = {i % 2 == 0, i % 2 == 1, 1'b1,
              i > 0 && (i - 1) % 2 == 0, i > 0 && (i - 1) % 2 == 1, i > 0};
      want_addr = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
      @(negedge clk_i);
      n_checks++;
      if (status() !== want) begin
        n_fail++; $display("[TB] FAIL rr_status i%0d: got %b want %b", i, status(), want);
      end
      n_checks++;
      if (instr_addr_o !== want_addr) begin
        n_fail++; $display("[TB] FAIL rr_addr i%0d: got %h want %h", i, instr_addr_o, want_addr);
      end
      next_cycle();
    end
    idle_inputs(); instr_rvalid_i = 1;
    @(negedge clk_i);
    n_checks++;
    if (status() !== 6'b000011) begin
      n_fail++; $display("[TB] FAIL rr_last_resp: got %b want %b", status(), 6'b000011);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_wait_lock();
    logic [5:0]  want [7] = '{6'b001000, 6'b001000, 6'b001000, 6'b011000,
                              6'b101001, 6'b000011, 6'b000101};
    logic [31:0] want_addr;
    reset_dut();
    req1_i = 1; addr1_i = 32'h1A11_0800; addr0_i = 32'h0000_0004;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) begin req0_i = 1; addr0_i = 32'h0000_0100; end
      if (c == 3) instr_gnt_i = 1;
      if (c == 4) req1_i = 0;
      if (c == 5) begin idle_inputs(); instr_rvalid_i = 1; end
      want_addr = (c == 4) ? 32'h0000_0100 : 32'h1A11_0800;
      @(negedge clk_i);
      n_checks++;
      if (status() !== want[c]) begin
        n_fail++; $display("[TB] FAIL lock_status c%0d: got %b want %b", c, status(), want[c]);
      end
      if (c < 5) begin
        n_checks++;
        if (instr_addr_o !== want_addr) begin
          n_fail++; $display("[TB] FAIL lock_addr c%0d: got %h want %h", c, instr_addr_o, want_addr);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_full();
    logic [5:0] want [8] = '{6'b101000, 6'b101001, 6'b000001, 6'b000101,
                             6'b101001, 6'b000101, 6'b000101, 6'b000000};
    reset_dut();
    req0_i = 1; addr0_i = 32'h0000_0040; instr_gnt_i = 1;
    for (int c = 0; c < 8; c++) begin
      instr_rvalid_i = (c == 3 || c == 5 || c == 6);
      if (c == 5) begin req0_i = 0; instr_gnt_i = 0; end
      @(negedge clk_i);
      n_checks++;
      if (status() !== want[c]) begin
        n_fail++; $display("[TB] FAIL full_status c%0d: got %b want %b", c, status(), want[c]);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_err();
    logic [5:0] want [5] = '{6'b011000, 6'b101001, 6'b000011, 6'b000101, 6'b000000};
    reset_dut();
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      if (c == 0) begin req1_i = 1; addr1_i = 32'h0000_0300; instr_gnt_i = 1; end
      if (c == 1) begin req0_i = 1; addr0_i = 32'h0000_0400; instr_gnt_i = 1; end
      if (c == 2) begin instr_rvalid_i = 1; instr_err_i = 1; instr_rdata_i = 32'hDEAD_BEEF; end
      if (c == 3) begin instr_rvalid_i = 1; instr_rdata_i = 32'h0000_0001; end
      @(negedge clk_i);
      n_checks++;
      if (status() !== want[c]) begin
        n_fail++; $display("[TB] FAIL err_status c%0d: got %b want %b", c, status(), want[c]);
      end
      if (c == 2 || c == 3) begin
        n_checks++;
        if (err_o !== (c == 2)) begin
          n_fail++; $display("[TB] FAIL err_flag c%0d: got %b want %b", c, err_o, c == 2);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] want [6] = '{6'b101000, 6'b011001, 6'b000000, 6'b000000, 6'b101000, 6'b000101};
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      rst_i = (c == 2);
      if (c == 0) begin req0_i = 1; addr0_i = 32'h0000_0500; instr_gnt_i = 1; end
      if (c == 1) begin req1_i = 1; addr1_i = 32'h0000_0600; instr_gnt_i = 1; end
      if (c == 2) req0_i = 1;
      if (c == 3) begin instr_rvalid_i = 1; instr_rdata_i = 32'h0000_0077; end
      if (c == 4) begin req0_i = 1; req1_i = 1; instr_gnt_i = 1; end
      if (c == 5) instr_rvalid_i = 1;
      @(negedge clk_i);
      n_checks++;
      if (status() !== want[c]) begin
        n_fail++; $display("[TB] FAIL rstmid_status c%0d: got %b want %b", c, status(), want[c]);
      end
      next_cycle();
    end
    rst_i = 0;
    idle_inputs();
  endtask

  task automatic test_random();
    int         q[$];
    int         last = 1;
    int         commit = -1;
    int         sel;
    logic       ereq, eg, pop, g0_prev, g1_prev;
    int         head;
    logic [5:0] want;
    reset_dut();
    g0_prev = 0; g1_prev = 0;
    for (int c = 0; c < 300; c++) begin
      // A requester keeps its request until granted, then may issue a new one.
      if (!req0_i || g0_prev) begin
        req0_i = $urandom_range(0, 1);
        if (req0_i) addr0_i = $urandom;
      end
      if (!req1_i || g1_prev) begin
        req1_i = $urandom_range(0, 1);
        if (req1_i) addr1_i = $urandom;
      end
      instr_gnt_i    = $urandom_range(0, 1);
      instr_rvalid_i = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      instr_rdata_i  = $urandom;
      instr_err_i    = $urandom_range(0, 1);

      if (commit >= 0)            sel = commit;
      else if (req0_i && !req1_i) sel = 0;
      else if (!req0_i && req1_i) sel = 1;
      else if (req0_i && req1_i)  sel = 1 - last;
      else                        sel = 0;
      ereq = ((sel == 1) ? req1_i : req0_i) && (q.size() < MaxOut);
      eg   = ereq && instr_gnt_i;
      pop  = instr_rvalid_i && (q.size() > 0);
      head = pop ? q[0] : 0;
      want = {eg && sel == 0, eg && sel == 1, ereq, pop && head == 0, pop && head == 1, q.size() > 0};

      @(negedge clk_i);
      n_checks++;
      if (status() !== want) begin
        n_fail++; $display("[TB] FAIL rand_status c%0d: got %b want %b", c, status(), want);
      end
      if (ereq) begin
        n_checks++;
        if (instr_addr_o !== ((sel == 1) ? addr1_i : addr0_i)) begin
          n_fail++; $display("[TB] FAIL rand_addr c%0d: got %h want %h", c, instr_addr_o,
                             (sel == 1) ? addr1_i : addr0_i);
        end
      end
      if (pop) begin
        n_checks++;
        if ({rdata_o, err_o} !== {instr_rdata_i, instr_err_i}) begin
          n_fail++; $display("[TB] FAIL rand_resp c%0d: got %h/%b want %h/%b", c, rdata_o, err_o,
                             instr_rdata_i, instr_err_i);
        end
      end

      if (pop) void'(q.pop_front());
      if (eg) begin
        q.push_back(sel);
        last   = sel;
        commit = -1;
      end else if (ereq) begin
        commit = sel;
      end else begin
        commit = -1;
      end
      g0_prev = eg && sel == 0;
      g1_prev = eg && sel == 1;
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wait_lock();
    test_full();
    test_err();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
